// File: rtl/chunked_addsub_unit.sv
// Multi-cycle add/subtract unit that ripples a registered carry through CHUNK-bit slices.
// Results and flags update only on the completion edge.
module chunked_addsub_unit #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);
    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    int unsigned      base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_res;
    logic             msb_carry_in;

    always_comb begin
        base         = CHUNK * 32'(idx_q);
        a_chunk      = a_q[base +: CHUNK];
        b_chunk      = b_q[base +: CHUNK];
        chunk_res    = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        // Carry into the top bit recovered from the top bit's own sum: s = a ^ b ^ cin.
        msb_carry_in = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_res[CHUNK-1];

        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        done_d      = 1'b0;

        if (state_q == IDLE) begin
            if (start) begin
                a_d     = a;
                b_d     = sub ? ~b : b;
                carry_d = carry_in ^ sub;
                idx_d   = '0;
                state_d = RUN;
            end
        end else begin
            acc_d[base +: CHUNK] = chunk_res[CHUNK-1:0];
            carry_d              = chunk_res[CHUNK];
            idx_d                = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
                sum_d       = acc_d;
                carry_out_d = chunk_res[CHUNK];
                overflow_d  = msb_carry_in ^ chunk_res[CHUNK];
                zero_d      = (acc_d == '0);
                done_d      = 1'b1;
                idx_d       = '0;
                state_d     = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            acc_q       <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_chunked_addsub_unit.sv
// Scoreboard bench for chunked_addsub_unit: a 64/16 instance and a 64/64 instance.
module tb_chunked_addsub_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [63:0] a_i = '0;
    logic [63:0] b_i = '0;
    logic        cin_i = 1'b0;
    logic        sub_i = 1'b0;

    logic        busy0, done0, cout0, ov0, zero0;
    logic [63:0] sum0;
    logic        busy1, done1, cout1, ov1, zero1;
    logic [63:0] sum1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [63:0] s;
        logic        c;
        logic        o;
        logic        z;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    chunked_addsub_unit #(.WIDTH(64), .CHUNK(16)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .a(a_i), .b(b_i),
        .carry_in(cin_i), .sub(sub_i), .busy(busy0), .done(done0),
        .sum(sum0), .carry_out(cout0), .overflow(ov0), .zero(zero0)
    );

    chunked_addsub_unit #(.WIDTH(64), .CHUNK(64)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .a(a_i), .b(b_i),
        .carry_in(cin_i), .sub(sub_i), .busy(busy1), .done(done1),
        .sum(sum1), .carry_out(cout1), .overflow(ov1), .zero(zero1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: pop and compare on every done pulse, sampled on the falling edge.
    always @(negedge clk) begin
        if (done0) begin
            chk("dut0_expected_result_pending", 64'(q0.size() != 0), 64'd1);
            if (q0.size() != 0) begin
                exp_t e;
                e = q0.pop_front();
                chk("dut0_sum", sum0, e.s);
                chk("dut0_carry_out", 64'(cout0), 64'(e.c));
                chk("dut0_overflow", 64'(ov0), 64'(e.o));
                chk("dut0_zero", 64'(zero0), 64'(e.z));
            end
        end
    end

    always @(negedge clk) begin
        if (done1) begin
            chk("dut1_expected_result_pending", 64'(q1.size() != 0), 64'd1);
            if (q1.size() != 0) begin
                exp_t e;
                e = q1.pop_front();
                chk("dut1_sum", sum1, e.s);
                chk("dut1_carry_out", 64'(cout1), 64'(e.c));
                chk("dut1_overflow", 64'(ov1), 64'(e.o));
                chk("dut1_zero", 64'(zero1), 64'(e.z));
            end
        end
    end

    task automatic push(input int d, input logic [63:0] s, input logic c, input logic o, input logic z);
        exp_t e;
        e = '{s: s, c: c, o: o, z: z};
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic issue(input int d, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic sub, input logic [63:0] s,
                         input logic c, input logic o, input logic z);
        @(negedge clk);
        a_i = a; b_i = b; cin_i = cin; sub_i = sub;
        if (d == 0) start0 = 1'b1;
        else start1 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0; start1 = 1'b0;
        push(d, s, c, o, z);
        chk("busy_after_accept", 64'((d == 0) ? busy0 : busy1), 64'd1);
    endtask

    task automatic wait_done(input int d, input int lat0, input int lat_exp, input string name);
        int   lat;
        logic seen;
        lat  = lat0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            seen = (d == 0) ? done0 : done1;
        end
        chk({name, "_latency"}, 64'(lat), 64'(lat_exp));
        chk({name, "_busy_at_done"}, 64'((d == 0) ? busy0 : busy1), 64'd0);
        @(posedge clk);
        #1;
        chk({name, "_done_width"}, 64'((d == 0) ? done0 : done1), 64'd0);
    endtask

    task automatic run_op(input int d, input string name, input logic [63:0] a,
                          input logic [63:0] b, input logic cin, input logic sub,
                          input logic [63:0] s, input logic c, input logic o, input logic z);
        issue(d, a, b, cin, sub, s, c, o, z);
        wait_done(d, 0, (d == 0) ? 4 : 1, name);
    endtask

    initial begin
        #12;
        chk("rst_busy0", 64'(busy0), 64'd0);
        chk("rst_done0", 64'(done0), 64'd0);
        chk("rst_sum0", sum0, 64'd0);
        chk("rst_flags0", 64'({cout0, ov0, zero0}), 64'd0);
        chk("rst_busy1", 64'(busy1), 64'd0);
        chk("rst_sum1", sum1, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(0, "add_basic", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
               64'h2222_2222_2222_2211, 1'b0, 1'b0, 1'b0);
        run_op(0, "ripple_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
               64'd0, 1'b1, 1'b0, 1'b1);
        run_op(0, "ones_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_op(0, "signed_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
        run_op(0, "sub_5_7", 64'd5, 64'd7, 1'b0, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_op(0, "sub_7_5", 64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0, 1'b0);
        run_op(0, "sub_7_5_borrow", 64'd7, 64'd5, 1'b1, 1'b1, 64'd1, 1'b1, 1'b0, 1'b0);
        run_op(0, "sub_equal", 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1,
               64'd0, 1'b1, 1'b0, 1'b1);

        // Start while busy must be ignored; the first operation's result comes back.
        issue(0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0002, 1'b0, 1'b0,
              64'd3, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        a_i = 64'h1111_1111_1111_1111; b_i = 64'h4444_4444_4444_4444;
        cin_i = 1'b1; sub_i = 1'b1; start0 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start0 = 1'b0;
        wait_done(0, 2, 4, "busy_ignore");

        // Abort in the second RUN cycle: everything clears at once, no done follows.
        @(negedge clk);
        a_i = 64'd1; b_i = 64'd1; cin_i = 1'b0; sub_i = 1'b0; start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_busy", 64'(busy0), 64'd0);
        chk("abort_done", 64'(done0), 64'd0);
        chk("abort_sum", sum0, 64'd0);
        chk("abort_carry_out", 64'(cout0), 64'd0);
        chk("abort_overflow", 64'(ov0), 64'd0);
        chk("abort_zero", 64'(zero0), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", 64'(done0), 64'd0);
        end
        run_op(0, "after_abort", 64'd100, 64'd58, 1'b0, 1'b1, 64'd42, 1'b1, 1'b0, 1'b0);

        // Single-chunk instance: latency 1 and back-to-back acceptance in the done cycle.
        run_op(1, "n1_add", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
               64'h2222_2222_2222_2211, 1'b0, 1'b0, 1'b0);
        issue(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("b2b_first_done", 64'(done1), 64'd1);
        a_i = 64'h7FFF_FFFF_FFFF_FFFF; b_i = 64'd1; cin_i = 1'b0; sub_i = 1'b0;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        push(1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
        chk("b2b_accepted_busy", 64'(busy1), 64'd1);
        chk("b2b_first_done_width", 64'(done1), 64'd0);
        @(posedge clk);
        #1;
        chk("b2b_second_done", 64'(done1), 64'd1);
        @(posedge clk);
        #1;
        chk("b2b_second_done_width", 64'(done1), 64'd0);

        repeat (4) @(posedge clk);
        chk("dut0_queue_drained", 64'(q0.size()), 64'd0);
        chk("dut1_queue_drained", 64'(q1.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
